// File: rtl/velocity_update_sequencer.sv
// Walks a cell's velocity words: reads the particle count at address 0, then streams each
// velocity out for update and writes the result back. Optional cycle counter: VEL_SEQ_CYCLE_CNT_EN.
module velocity_update_sequencer #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] v_out,
    output logic [ADDR_WIDTH-1:0] v_out_id,
    output logic                  v_out_valid,
    input  logic                  v_out_ready,
    input  logic [DATA_WIDTH-1:0] v_in,
    input  logic                  v_in_valid,
    output logic                  v_in_ready
`ifdef VEL_SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0]           cycle_count
`endif
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_INDEX = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [3:0] {
        IDLE, RD_CNT, WAIT_CNT, RD_V, WAIT_V, SEND, RECV, WRITE, FIN
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [LAT_W-1:0]        lat_cnt;
    logic [ADDR_WIDTH-1:0]   index;
    logic [DATA_WIDTH-1:0]   v_in_reg;
    logic [ADDR_WIDTH-1:0]   raw_count;
    logic                    lat_done;
    logic                    accept;
    logic                    more;

    // A count word beyond the memory depth saturates to the last usable address.
    function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
        return (raw > MAX_INDEX) ? MAX_INDEX : raw;
    endfunction

    assign raw_count = mem_q[ADDR_WIDTH-1:0];
    assign lat_done  = (lat_cnt == LAT_W'(READ_LATENCY - 1));
    assign accept    = (state == IDLE) && start;
    assign more      = (index < particle_count);
    assign v_out_id  = index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = RD_CNT;
            RD_CNT:   next_state = WAIT_CNT;
            WAIT_CNT: if (lat_done) next_state = (raw_count == '0) ? FIN : RD_V;
            RD_V:     next_state = WAIT_V;
            WAIT_V:   if (lat_done) next_state = SEND;
            SEND:     if (v_out_ready) next_state = RECV;
            RECV:     if (v_in_valid) next_state = WRITE;
            WRITE:    next_state = more ? RD_V : FIN;
            FIN:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        done        = 1'b0;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        v_out_valid = 1'b0;
        v_in_ready  = 1'b0;
        case (state)
            RD_CNT: mem_rden = 1'b1;
            RD_V: begin
                mem_rden    = 1'b1;
                mem_address = index;
            end
            SEND:   v_out_valid = 1'b1;
            RECV:   v_in_ready  = 1'b1;
            WRITE: begin
                mem_wren    = 1'b1;
                mem_address = index;
                mem_data    = v_in_reg;
            end
            FIN:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers: latency counter, count/index, captured velocities.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt        <= '0;
            index          <= '0;
            particle_count <= '0;
            count_err      <= 1'b0;
            v_out          <= '0;
            v_in_reg       <= '0;
        end else begin
            if ((state == WAIT_CNT) || (state == WAIT_V)) begin
                lat_cnt <= lat_done ? '0 : lat_cnt + LAT_W'(1);
            end else begin
                lat_cnt <= '0;
            end
            if (accept) begin
                count_err <= 1'b0;
            end
            if ((state == WAIT_CNT) && lat_done) begin
                particle_count <= clamp_count(raw_count);
                count_err      <= (raw_count > MAX_INDEX);
                index          <= ADDR_WIDTH'(1);
            end
            if ((state == WAIT_V) && lat_done) begin
                v_out <= mem_q;
            end
            if ((state == RECV) && v_in_valid) begin
                v_in_reg <= v_in;
            end
            if ((state == WRITE) && more) begin
                index <= index + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef VEL_SEQ_CYCLE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if (accept) begin
            cycle_count <= '0;
        end else if (busy) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_velocity_update_sequencer.sv
// Bench for velocity_update_sequencer: memory + motion-unit models, write-back scoreboard,
// table of count words, plus stall, reset-abort and extra-start sequences.
module tb_velocity_update_sequencer;

    localparam int DW = 96;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, count_err;
    logic [AW-1:0] particle_count, mem_address, v_out_id;
    logic [DW-1:0] mem_data, mem_q, v_out, v_in;
    logic          mem_rden, mem_wren, v_out_valid, v_out_ready, v_in_valid, v_in_ready;
`ifdef VEL_SEQ_CYCLE_CNT_EN
    logic [31:0]   cycle_count;
`endif

    velocity_update_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(220), .READ_LATENCY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .count_err(count_err), .particle_count(particle_count),
        .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden),
        .mem_wren(mem_wren), .mem_q(mem_q), .v_out(v_out), .v_out_id(v_out_id),
        .v_out_valid(v_out_valid), .v_out_ready(v_out_ready), .v_in(v_in),
        .v_in_valid(v_in_valid), .v_in_ready(v_in_ready)
`ifdef VEL_SEQ_CYCLE_CNT_EN
        , .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] vel(input int i);
        return {32'(i * 3 + 1), 32'(i * 7 + 2), 32'(i) ^ 32'h5A5A_0000};
    endfunction

    function automatic logic [DW-1:0] mk_vin(input logic [DW-1:0] v);
        return {v[95:64] + 32'd1, v[63:32] - 32'd1, v[31:0] ^ 32'h0000_FFFF};
    endfunction

    // Cell memory model with two-cycle registered read.
    logic [DW-1:0] mem [0:255];
    logic          init_req = 1'b0;
    int            init_cw = 0;
    logic          rd_v1 = 1'b0;
    logic [AW-1:0] rd_a1 = '0;
    initial mem_q = '0;

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 0) ? DW'(init_cw) : vel(i);
        end else if (mem_wren) begin
            mem[mem_address] <= mem_data;
        end
        rd_v1 <= mem_rden;
        rd_a1 <= mem_address;
        if (rd_v1) mem_q <= mem[rd_a1];
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } sb_t;
    sb_t sb[$];

    int rd_cnt, wr_cnt, exp_rd_addr, last_wr, done_cnt, busy_cycles;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rden) begin
                rd_cnt++;
                chk("rd_addr", mem_address, exp_rd_addr);
                exp_rd_addr++;
            end
            if (mem_wren) begin
                sb_t e;
                wr_cnt++;
                last_wr = mem_address;
                chk("wr_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wr_addr", mem_address, e.a);
                    chk("wr_data", mem_data, e.d);
                end
            end
            if (mem_rden || mem_wren) chk("rd_wr_exclusive", mem_rden & mem_wren, 0);
            if (busy) busy_cycles++;
            if (done) done_cnt++;
        end
    end

    // Motion-unit model: optional 5-cycle stall on one id, then returns an updated velocity.
    int vin_delay = 0;
    int stall_id = 0;
    logic [DW-1:0] hold_v, exp_v;
    logic [AW-1:0] hold_id;

    initial begin
        v_out_ready = 1'b1;
        v_in_valid  = 1'b0;
        v_in        = '0;
        forever begin
            @(negedge clk);
            if (rst_n && v_out_valid) begin
                if (int'(v_out_id) == stall_id) begin
                    v_out_ready = 1'b0;
                    hold_v  = v_out;
                    hold_id = v_out_id;
                    for (int k = 0; k < 5; k++) begin
                        if (k > 0) @(negedge clk);
                        chk("stall_v_out", v_out, hold_v);
                        chk("stall_v_out_id", v_out_id, hold_id);
                        chk("stall_valid", v_out_valid, 1);
                        chk("stall_no_mem", {mem_rden, mem_wren}, 0);
                    end
                    @(negedge clk);
                    v_out_ready = 1'b1;
                end
                chk("v_out_data", v_out, vel(int'(v_out_id)));
                exp_v = mk_vin(v_out);
                sb.push_back({v_out_id, exp_v});
                @(negedge clk);
                for (int k = 0; k < vin_delay; k++) begin
                    chk("recv_waiting", v_in_ready, 1);
                    @(negedge clk);
                end
                chk("v_in_ready", v_in_ready, 1);
                v_in       = exp_v;
                v_in_valid = 1'b1;
                @(negedge clk);
                v_in_valid = 1'b0;
                v_in       = '0;
            end
        end
    end

    task automatic load_mem(input int cw);
        init_cw = cw;
        @(negedge clk);
        init_req = 1'b1;
        @(posedge clk);
        #1 init_req = 1'b0;
    endtask

    task automatic clear_logs();
        sb.delete();
        rd_cnt = 0; wr_cnt = 0; exp_rd_addr = 0; last_wr = 0; done_cnt = 0; busy_cycles = 0;
    endtask

    task automatic run_pass(input int cw, input int exp_pc, input bit exp_err,
                            input int vdelay, input int stall, input int extra_at);
        int cyc;
        load_mem(cw);
        vin_delay = vdelay;
        stall_id  = stall;
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("count_err_cleared", count_err, 0);
        cyc = 0;
        while (done_cnt == 0 && cyc < 12 * exp_pc + 40) begin
            start = (extra_at >= 0 && cyc == extra_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", done_cnt != 0, 1);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("busy_low", busy, 0);
        chk("particle_count", particle_count, exp_pc);
        chk("count_err", count_err, exp_err);
        chk("writes", wr_cnt, exp_pc);
        chk("reads", rd_cnt, exp_pc + 1);
        if (exp_pc > 0) chk("last_write_addr", last_wr, exp_pc);
        chk("sb_drained", sb.size(), 0);
        chk("idle_ctrl", {mem_rden, mem_wren, v_out_valid, v_in_ready}, 0);
`ifdef VEL_SEQ_CYCLE_CNT_EN
        chk("cycle_count", cycle_count, busy_cycles);
`endif
    endtask

    function automatic logic [255:0] all_outs();
        return {busy, done, count_err, particle_count, mem_address, mem_data,
                mem_rden, mem_wren, v_out, v_out_id, v_out_valid, v_in_ready};
    endfunction

    typedef struct {
        int cw;
        int exp_pc;
        bit exp_err;
        int vdelay;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int cyc, rd_snap, wr_snap;
        vecs[0] = '{3,   3,   1'b0, 0};
        vecs[1] = '{0,   0,   1'b0, 0};
        vecs[2] = '{1,   1,   1'b0, 2};
        vecs[3] = '{250, 219, 1'b1, 0};
        vecs[4] = '{219, 219, 1'b0, 1};
        vecs[5] = '{220, 219, 1'b1, 0};
        vecs[6] = '{5,   5,   1'b0, 3};

        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
`ifdef VEL_SEQ_CYCLE_CNT_EN
        chk("reset_cycle_count", cycle_count, 0);
`endif
        rst_n = 1'b1;

        foreach (vecs[i]) run_pass(vecs[i].cw, vecs[i].exp_pc, vecs[i].exp_err, vecs[i].vdelay, 0, -1);

        // Back-pressure on index 2.
        run_pass(3, 3, 1'b0, 0, 2, -1);

        // Extra start while busy must be ignored.
        run_pass(3, 3, 1'b0, 0, 0, 6);

        // Reset asserted while index 2 is being written.
        load_mem(5);
        vin_delay = 0;
        stall_id  = 0;
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(mem_wren && mem_address == 2) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_write2", mem_wren && mem_address == 2, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_outputs", all_outs(), 0);
        @(posedge clk);
        #1;
        chk("write2_aborted", mem[2], vel(2));
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold_outputs", all_outs(), 0);
        end
        rst_n = 1'b1;
        rd_snap = rd_cnt;
        wr_snap = wr_cnt;
        repeat (10) @(negedge clk);
        chk("no_resume_reads", rd_cnt, rd_snap);
        chk("no_resume_writes", wr_cnt, wr_snap);
        chk("no_resume_busy", busy, 0);
        run_pass(3, 3, 1'b0, 0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/velocity_update_sequencer.md
VELOCITY_UPDATE_SEQUENCER -- requirements
Module: velocity_update_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, velocity word width packed {vz, vy, vx}, 32 bits each.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, cell memory address width.
REQ-003 SHALL have parameter PARTICLE_NUM, default 220, cell memory depth in words.
REQ-004 SHALL have parameter READ_LATENCY, default 2, cycles from mem_rden high to valid mem_q.
REQ-005 SHALL have ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a cell pass.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse ending a pass.
- count_err  out  1  sticky per pass; particle count was clamped.
- particle_count  out  ADDR_WIDTH  count latched from address 0.
- mem_address  out  ADDR_WIDTH  cell memory address.
- mem_data  out  DATA_WIDTH  cell memory write data.
- mem_rden  out  1  cell memory read enable.
- mem_wren  out  1  cell memory write enable.
- mem_q  in  DATA_WIDTH  cell memory read data.
- v_out  out  DATA_WIDTH  velocity sent to the motion-update unit.
- v_out_id  out  ADDR_WIDTH  address of v_out.
- v_out_valid / v_out_ready  out / in  1  handshake for the outgoing velocity.
- v_in  in  DATA_WIDTH  updated velocity.
- v_in_valid / v_in_ready  in / out  1  handshake for the incoming velocity.

Function
REQ-006 SHALL implement FSM states IDLE, RD_CNT, WAIT_CNT, RD_V, WAIT_V, SEND, RECV, WRITE, FIN.
REQ-007 IDLE->RD_CNT on start; start SHALL be ignored in every other state.
REQ-008 RD_CNT SHALL drive mem_address=0 and mem_rden=1 for one cycle, then go to WAIT_CNT.
REQ-009 WAIT_CNT SHALL wait READ_LATENCY cycles, then latch mem_q[ADDR_WIDTH-1:0] into particle_count.
REQ-010 If the latched count > PARTICLE_NUM-1, it SHALL be clamped to PARTICLE_NUM-1 and count_err set.
REQ-011 If the count = 0, the FSM SHALL go to FIN without any particle access; otherwise the particle index SHALL start at 1.
REQ-012 RD_V SHALL issue one read of the current index, and WAIT_V SHALL capture mem_q after READ_LATENCY cycles into v_out.
REQ-013 SEND SHALL assert v_out_valid and hold v_out and v_out_id stable until v_out_ready is high, then go to RECV.
REQ-014 RECV SHALL assert v_in_ready, and on v_in_valid SHALL capture v_in and go to WRITE; v_in_ready SHALL be 0 outside RECV.
REQ-015 WRITE SHALL drive mem_wren=1, mem_address=index and mem_data=captured v_in for exactly one cycle.
REQ-016 After WRITE, the FSM SHALL go to RD_V with index+1 if index < count, else to FIN.
REQ-017 FIN SHALL pulse done for one cycle and return to IDLE, where busy=0.
REQ-018 mem_rden and mem_wren SHALL never be high in the same cycle.
REQ-019 Address 0 SHALL never be written.
REQ-020 At most one particle SHALL be in flight.
REQ-021 mem_rden, mem_wren, v_out_valid and v_in_ready SHALL be 0 in IDLE and FIN.
REQ-022 count_err SHALL clear on the next accepted start.

Reset
REQ-023 While rst_n=0, the FSM SHALL be IDLE and every output SHALL be 0, including the data and address buses.
REQ-024 Reset mid-pass SHALL abort immediately with no further memory write; the pass SHALL NOT resume after release.

Configuration
REQ-025 With VEL_SEQ_CYCLE_CNT_EN defined, the block SHALL add output cycle_count[31:0]:
- clears on an accepted start;
- increments each cycle while busy;
- holds its value after done;
- resets to 0.
REQ-026 Without VEL_SEQ_CYCLE_CNT_EN, the cycle_count port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Count word 3, ready tied high, v_in_valid one cycle after v_out accepted -> reads of addresses 0,1,2,3; writes of addresses 1,2,3 with the returned data; done once; busy low after.
REQ-028 Count word 0 -> only the address-0 read occurs, done pulses, no mem_wren.
REQ-029 Count word 250 with PARTICLE_NUM=220 -> particle_count=219, count_err=1, last write at address 219.
REQ-030 v_out_ready held low 5 cycles at index 2 -> v_out and v_out_id stable for all 5 cycles; no read or write during the stall.
REQ-031 rst_n low during WRITE of index 2 -> no further mem_wren; outputs 0; a following start reruns from address 0.
REQ-032 start pulsed while busy, and with VEL_SEQ_CYCLE_CNT_EN defined -> the extra start is ignored; cycle_count equals the measured busy cycles.
